cc_port_arbiter: RTL and testbench

- Shares the single L1 cache controller between NUM_REQ processor-side requesters.
- Accepts one read, write or flush at a time and drives the controller's read_c/write_c/cache_flush strobes, address and write data.
- Waits for the controller's completion pulse, then returns read data and status to the granted requester.
- Sits between the processor ports and the cache controller; arbitration is round-robin.

---
 rtl/cc_arb_pkg.sv | 19 +
 rtl/cc_rr_arbiter.sv | 31 +++
 rtl/cc_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_cc_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_arb_pkg.sv
// cc_arb_pkg: op codes and FSM states for the L1 cache port arbiter.
// Shared by cc_port_arbiter and its round-robin picker.
package cc_arb_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_FLUSH   = 2'b10,
    OP_ILLEGAL = 2'b11
  } cc_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } cc_arb_state_e;

endpackage

// File: rtl/cc_rr_arbiter.sv
// cc_rr_arbiter: combinational round-robin pick starting at ptr.
// Yields a one-hot grant, its index and an any-valid flag.
module cc_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_valid
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/cc_port_arbiter.sv
// cc_port_arbiter: shares one L1 cache controller between NUM_REQ ports.
// Optional WAIT timeout is enabled by defining CC_ARB_TIMEOUT_EN.
module cc_port_arbiter
  import cc_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
`ifdef CC_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [2*NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        cc_read_c,
  output logic                        cc_write_c,
  output logic                        cc_flush,
  output logic [ADDR_W-1:0]           cc_address,
  output logic [DATA_W-1:0]           cc_data_mp_to_c,
  input  logic [DATA_W-1:0]           cc_data_c_to_mp,
  input  logic                        cc_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int IW = $clog2(NUM_REQ);

  cc_arb_state_e state, state_nxt;
  cc_op_e        op_q, win_op;
  logic [IW-1:0]      rr_ptr, grant_q, win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               any_valid, accept, tmo, issue;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, rdata_q;
  logic               err_q;

  cc_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt       (win_oh),
    .gnt_idx   (win_idx),
    .any_valid (any_valid)
  );

  assign win_op = cc_op_e'(req_op[2*int'(win_idx) +: 2]);
  assign accept = (state == IDLE) && any_valid;

`ifdef CC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end

  // a completion on the limit cycle wins over the timeout
  assign tmo = (state == WAIT) && !cc_done &&
               (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = (op_q == OP_ILLEGAL) ? RESP : WAIT;
      WAIT:    if (cc_done || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        grant_q <= win_idx;
        op_q    <= win_op;
        addr_q  <= req_addr[ADDR_W*int'(win_idx) +: ADDR_W];
        wdata_q <= (win_op == OP_WRITE) ?
                   req_wdata[DATA_W*int'(win_idx) +: DATA_W] : '0;
      end
      if (state == ISSUE && op_q == OP_ILLEGAL) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (state == WAIT && (cc_done || tmo)) begin
        rdata_q <= (cc_done && op_q == OP_READ) ? cc_data_c_to_mp : '0;
        err_q   <= !cc_done;
      end
      if (state == RESP)
        rr_ptr <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  assign issue = !rst && (state == ISSUE);

  always_comb begin
    cc_read_c  = 1'b0;
    cc_write_c = 1'b0;
    cc_flush   = 1'b0;
    unique case (1'b1)
      issue && op_q == OP_READ:  cc_read_c  = 1'b1;
      issue && op_q == OP_WRITE: cc_write_c = 1'b1;
      issue && op_q == OP_FLUSH: cc_flush   = 1'b1;
      default: ;
    endcase
  end

  // outputs forced low while reset is held, before registers clear
  assign req_ready       = (!rst && state == IDLE) ? win_oh : '0;
  assign rsp_valid       = (!rst && state == RESP) ?
                           (NUM_REQ'(1) << grant_q) : '0;
  assign rsp_err         = !rst && err_q;
  assign rsp_rdata       = rst ? '0 : rdata_q;
  assign cc_address      = rst ? '0 : addr_q;
  assign cc_data_mp_to_c = rst ? '0 : wdata_q;
  assign grant_id        = rst ? '0 : grant_q;
  assign busy            = !rst && (state != IDLE);

endmodule

// File: tb/tb_cc_port_arbiter.sv
// tb_cc_port_arbiter: directed and random stimulus for cc_port_arbiter,
// checked every cycle against a transaction-timeline model.
module tb_cc_port_arbiter;

  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int IW  = 2;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [2*N-1:0]  req_op;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_err, cc_read_c, cc_write_c, cc_flush, cc_done, busy;
  logic [DW-1:0]   rsp_rdata, cc_data_mp_to_c, cc_data_c_to_mp;
  logic [AW-1:0]   cc_address;
  logic [IW-1:0]   grant_id;

  cc_port_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
`ifdef CC_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC (TMO)
`endif
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_op (req_op), .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid), .rsp_err (rsp_err), .rsp_rdata (rsp_rdata),
    .cc_read_c (cc_read_c), .cc_write_c (cc_write_c), .cc_flush (cc_flush),
    .cc_address (cc_address), .cc_data_mp_to_c (cc_data_mp_to_c),
    .cc_data_c_to_mp (cc_data_c_to_mp), .cc_done (cc_done),
    .grant_id (grant_id), .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h", nm, cyc, act, exp);
    end
  endtask

  // cache controller model knobs
  bit cc_rand, cc_spur, cc_fix;
  int cc_delay, done_at;

  // monitor observations
  logic [N-1:0] acc_now = '0;
  bit      rsp_now = 1'b0;
  int      acc_log[$], acc_cyc_q[$], rsp_cyc_q[$];
  int      mon_acc_cyc, mon_acc_id, mon_str_cyc, mon_rsp_cyc, mon_rsp_n = 0;
  int      mon_rd_n = 0, mon_wr_n = 0, mon_fl_n = 0;
  logic [AW-1:0] mon_str_addr;
  logic [DW-1:0] mon_str_data, mon_rsp_rdata;
  logic [N-1:0]  mon_rsp_vec;
  logic          mon_rsp_err;

  // reference model: one transaction timeline
  bit            m_idle = 1'b1;
  int            m_ptr = 0, m_id = 0, t_acc = 0, t_rsp = -1, w;
  logic [1:0]    m_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata = '0, n_rdata;
  logic          m_err = 1'b0, n_err;
  logic [N-1:0]  e_ready, e_rsp;
  logic [2:0]    e_str;
  logic          e_busy;
  int            e_gid;

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    acc_now = req_valid & req_ready;
    for (int i = 0; i < N; i++)
      if (acc_now[i]) begin
        acc_log.push_back(i);
        acc_cyc_q.push_back(cyc);
        mon_acc_id  = i;
        mon_acc_cyc = cyc;
      end
    if (cc_read_c || cc_write_c || cc_flush) begin
      mon_str_cyc  = cyc;
      mon_str_addr = cc_address;
      mon_str_data = cc_data_mp_to_c;
      mon_rd_n += int'(cc_read_c);
      mon_wr_n += int'(cc_write_c);
      mon_fl_n += int'(cc_flush);
      if (cc_rand) done_at = cyc + 1 + int'($urandom_range(0, 4));
      else if (cc_delay < 0) done_at = -1;
      else done_at = cyc + 1 + cc_delay;
    end
    rsp_now = |rsp_valid;
    if (rsp_now) begin
      mon_rsp_n++;
      mon_rsp_cyc   = cyc;
      mon_rsp_vec   = rsp_valid;
      mon_rsp_rdata = rsp_rdata;
      mon_rsp_err   = rsp_err;
      rsp_cyc_q.push_back(cyc);
    end

    if (rst) begin
      chk("rst_ctl", {req_ready, rsp_valid, rsp_err, cc_read_c,
                      cc_write_c, cc_flush, grant_id, busy}, '0);
      chk("rst_addr", cc_address, '0);
      chk("rst_wdata", cc_data_mp_to_c, '0);
      chk("rst_rdata", rsp_rdata, '0);
      m_idle = 1'b1; m_ptr = 0; m_id = 0; m_rdata = '0; m_err = 1'b0;
    end else begin
      if (!m_idle && t_rsp >= 0 && cyc > t_rsp) begin
        m_idle = 1'b1;
        m_ptr  = (m_id + 1) % N;
      end
      e_ready = '0; e_str = '0; e_rsp = '0;
      e_gid = m_id; e_busy = !m_idle;
      if (m_idle) begin
        w = rr_pick(req_valid, m_ptr);
        if (w >= 0) begin
          e_ready[w] = 1'b1;
          m_id    = w;
          m_op    = req_op[2*w +: 2];
          m_addr  = req_addr[AW*w +: AW];
          m_wdata = (m_op == 2'b01) ? req_wdata[DW*w +: DW] : '0;
          t_acc   = cyc;
          m_idle  = 1'b0;
          if (m_op == 2'b11) begin
            t_rsp = cyc + 2; n_rdata = '0; n_err = 1'b1;
          end else t_rsp = -1;
        end
      end else begin
        chk("addr", cc_address, m_addr);
        chk("wdata", cc_data_mp_to_c, m_wdata);
        if (cyc == t_acc + 1)
          case (m_op)
            2'b00:   e_str = 3'b100;
            2'b01:   e_str = 3'b010;
            2'b10:   e_str = 3'b001;
            default: e_str = 3'b000;
          endcase
        if (t_rsp < 0 && cyc >= t_acc + 2) begin
          if (cc_done) begin
            t_rsp   = cyc + 1;
            n_rdata = (m_op == 2'b00) ? cc_data_c_to_mp : '0;
            n_err   = 1'b0;
          end
`ifdef CC_ARB_TIMEOUT_EN
          else if (cyc == t_acc + 1 + TMO) begin
            t_rsp = cyc + 1; n_rdata = '0; n_err = 1'b1;
          end
`endif
        end
        if (cyc == t_rsp) begin
          m_rdata = n_rdata; m_err = n_err;
          e_rsp[m_id] = 1'b1;
        end
      end
      chk("ready", req_ready, e_ready);
      chk("strobe", {cc_read_c, cc_write_c, cc_flush}, e_str);
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
      chk("grant_id", grant_id, e_gid);
      chk("busy", busy, e_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cc_done = (cyc == done_at) || (cc_spur && $urandom_range(0, 15) == 0);
    cc_data_c_to_mp = cc_fix ? 32'hDEADBEEF : $urandom;
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [AW-1:0] a,
                         logic [DW-1:0] d);
    req_valid[i]        = 1'b1;
    req_op[2*i +: 2]    = op;
    req_addr[AW*i +: AW] = a;
    req_wdata[DW*i +: DW] = d;
  endtask

  task automatic wait_acc(int i);
    int n = 0;
    do begin tick(); n++; end while (!acc_now[i] && n < 64);
    chk("acc_wait", n < 64, 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(int lim);
    int n = 0;
    do begin tick(); n++; end while (!rsp_now && n < lim);
    chk("rsp_wait", n < lim, 1);
  endtask

  function automatic logic [1:0] rand_op();
    int r = $urandom_range(0, 7);
    if (r < 3) return 2'b00;
    if (r < 5) return 2'b01;
    if (r < 7) return 2'b10;
    return 2'b11;
  endfunction

  int n, base;

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
    cc_done = 1'b0; cc_data_c_to_mp = '0;
    cc_rand = 0; cc_spur = 0; cc_fix = 1; cc_delay = 0; done_at = -1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // fairness and minimum latency, writes from req0 and req1
    acc_log.delete(); acc_cyc_q.delete(); rsp_cyc_q.delete();
    base = mon_wr_n;
    set_req(0, 2'b01, 16'h0100, 32'hA000_0000);
    set_req(1, 2'b01, 16'h0104, 32'hB000_0000);
    n = 0;
    while (acc_log.size() < 4 && n < 100) begin
      tick(); n++;
      for (int i = 0; i < 2; i++)
        if (acc_now[i]) set_req(i, 2'b01, AW'(16'h0100 + 4*i), $urandom);
    end
    req_valid = '0;
    wait_rsp(20);
    chk("fair_cnt", acc_log.size(), 4);
    chk("fair_ids", acc_log[0]*1000 + acc_log[1]*100 +
                    acc_log[2]*10 + acc_log[3], 101);
    chk("b2b_gap", acc_cyc_q[1] - acc_cyc_q[0], 4);
    chk("b2b_lat", rsp_cyc_q[0] - acc_cyc_q[0], 3);
    chk("wr_pulses", mon_wr_n - base, 4);
    chk("wr_rdata", rsp_rdata, 0);

    // single read
    cc_delay = 2;
    base = mon_rd_n;
    set_req(0, 2'b00, 16'h0040, 32'h0);
    wait_acc(0);
    wait_rsp(20);
    chk("rd_pulses", mon_rd_n - base, 1);
    chk("rd_addr", mon_str_addr, 16'h0040);
    chk("rd_str_lat", mon_str_cyc - mon_acc_cyc, 1);
    chk("rd_rsp_lat", mon_rsp_cyc - mon_acc_cyc, 5);
    chk("rd_vec", mon_rsp_vec, 3'b001);
    chk("rd_data", mon_rsp_rdata, 32'hDEADBEEF);
    chk("rd_err", mon_rsp_err, 0);

    // flush then illegal op on req1
    cc_delay = 1;
    base = mon_fl_n;
    set_req(1, 2'b10, 16'h0200, 32'hFFFF_FFFF);
    wait_acc(1);
    wait_rsp(20);
    chk("fl_pulses", mon_fl_n - base, 1);
    chk("fl_data", mon_str_data, 0);
    chk("fl_vec", mon_rsp_vec, 3'b010);
    chk("fl_err", mon_rsp_err, 0);
    base = mon_rd_n + mon_wr_n + mon_fl_n;
    set_req(1, 2'b11, 16'h0300, 32'h1234);
    wait_acc(1);
    wait_rsp(20);
    chk("ill_strobes", mon_rd_n + mon_wr_n + mon_fl_n - base, 0);
    chk("ill_lat", mon_rsp_cyc - mon_acc_cyc, 2);
    chk("ill_vec", mon_rsp_vec, 3'b010);
    chk("ill_err", mon_rsp_err, 1);

    // wrap-around: after grant 2 the pointer returns to 0
    cc_delay = 0;
    set_req(2, 2'b00, 16'h0400, 32'h0);
    wait_acc(2);
    wait_rsp(20);
    set_req(0, 2'b00, 16'h0410, 32'h0);
    set_req(2, 2'b00, 16'h0420, 32'h0);
    n = 0;
    do begin tick(); n++; end while (acc_now == '0 && n < 20);
    chk("wrap_win", mon_acc_id, 0);
    req_valid[0] = 1'b0;
    wait_rsp(20);
    wait_acc(2);
    chk("wrap_next", mon_acc_id, 2);
    wait_rsp(20);

    // reset during WAIT drops the request; late cc_done is ignored
    cc_delay = 6;
    base = mon_rsp_n;
    set_req(0, 2'b00, 16'h0500, 32'h0);
    wait_acc(0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_gid", grant_id, 0);
    repeat (8) tick();
    chk("rst_no_rsp", mon_rsp_n - base, 0);
    chk("rst_idle", busy, 0);

`ifdef CC_ARB_TIMEOUT_EN
    cc_delay = -1;
    set_req(1, 2'b00, 16'h0600, 32'h0);
    wait_acc(1);
    wait_rsp(40);
    chk("tmo_lat", mon_rsp_cyc - mon_acc_cyc, TMO + 2);
    chk("tmo_err", mon_rsp_err, 1);
    chk("tmo_data", mon_rsp_rdata, 0);
`endif

    // random traffic
    cc_rand = 1; cc_spur = 1; cc_fix = 0;
    repeat (3000) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (acc_now[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, rand_op(), AW'($urandom), $urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          set_req(i, rand_op(), AW'($urandom), $urandom);
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
